// File: rtl/demux_1_8_dispatch_pkg.sv
// demux_ctrl_pkg: shared lane constants and dispatcher state encoding
package demux_ctrl_pkg;
    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/demux_1_8_dispatch_if.sv
// demux_1_8_dispatch_if: producer/lane handshake bundle; slave is the dispatcher
interface demux_1_8_dispatch_if
    import demux_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
);
    logic               mode;
    logic [N_LANES-1:0] lane_en;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SEL_W-1:0]   in_sel;
    logic [N_LANES-1:0] out_valid;
    logic [N_LANES-1:0] out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [SEL_W-1:0]   cur_lane;
    logic [SEL_W-1:0]   rr_ptr;
    logic [DROP_W-1:0]  drop_cnt;
    modport slave (
        input  mode, lane_en, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, cur_lane, rr_ptr, drop_cnt
    );
    modport master (
        output mode, lane_en, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, cur_lane, rr_ptr, drop_cnt
    );
endinterface

// File: rtl/demux_1_8_dispatch_rr_next_lane.sv
// rr_next_lane: first enabled lane at or after ptr, wrapping modulo N_LANES
module rr_next_lane
    import demux_ctrl_pkg::*;
(
    input  logic [N_LANES-1:0] i_lane_en,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_lane,
    output logic               o_found
);
    // Scan farthest-first so the nearest enabled lane is the last write
    always_comb begin
        o_lane = i_ptr;
        for (int k = N_LANES - 1; k >= 0; k--)
            if (i_lane_en[i_ptr + SEL_W'(k)]) o_lane = i_ptr + SEL_W'(k);
    end
    assign o_found = |i_lane_en;
endmodule

// File: rtl/demux_1_8_dispatch.sv
// demux_1_8_dispatch: one-word-in-flight dispatcher to 8 lanes, round-robin or directed,
// dropping directed words that target a disabled lane.
module demux_1_8_dispatch
    import demux_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DROP_W = 8
)(
    input logic                 clk,
    input logic                 rst,
    demux_1_8_dispatch_if.slave bus
);
    state_t             r_state;
    logic [DATA_W-1:0]  r_data;
    logic [SEL_W-1:0]   r_lane;
    logic [SEL_W-1:0]   r_rr;
    logic [DROP_W-1:0]  r_drop;
    logic [SEL_W-1:0]   w_rr_lane;
    logic [SEL_W-1:0]   w_target;
    logic               w_found;
    logic               w_xfer;
    logic               w_ready;
    logic               w_accept;
    logic               w_drop;

    rr_next_lane u_rr (
        .i_lane_en (bus.lane_en),
        .i_ptr     (r_rr),
        .o_lane    (w_rr_lane),
        .o_found   (w_found)
    );

    assign w_xfer   = (r_state == HOLD) && bus.out_ready[r_lane];
    // Round-robin with no enabled lane has nowhere to go, so stall the producer
    assign w_ready  = !rst && (bus.mode || w_found) && (r_state == IDLE || w_xfer);
    assign w_accept = bus.in_valid && w_ready;
    assign w_target = bus.mode ? bus.in_sel : w_rr_lane;
    assign w_drop   = bus.mode && !bus.lane_en[bus.in_sel];

    // A dropped word accepted in HOLD implies the held word transferred, so it falls to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_lane  <= '0;
            r_rr    <= '0;
            r_drop  <= '0;
        end else begin
            if (w_accept && !w_drop) begin
                r_state <= HOLD;
                r_data  <= bus.in_data;
                r_lane  <= w_target;
                if (!bus.mode) r_rr <= w_target + SEL_W'(1);
            end else if (w_xfer) begin
                r_state <= IDLE;
            end
            if (w_accept && w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_state == HOLD) ? (N_LANES'(1) << r_lane) : '0;
    assign bus.out_data  = r_data;
    assign bus.cur_lane  = r_lane;
    assign bus.rr_ptr    = r_rr;
    assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_demux_1_8_dispatch.sv
// tb_demux_1_8_dispatch: vector table, corner sequences and random traffic against a
// transaction-level model of the dispatcher.
module tb_demux_1_8_dispatch;
    import demux_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1_8_dispatch_if bus ();
    demux_1_8_dispatch dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    bit m_hold;
    int m_lane, m_data, m_rr, m_drop;

    typedef struct {
        bit         md;
        logic [7:0] en;
        bit         v;
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] ordy;
        bit         rdy;
        logic [7:0] ov;
        logic [7:0] od;
        logic [2:0] rr;
    } vec_t;
    vec_t tbl[22];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_scan(int ptr, logic [7:0] en);
        for (int i = 0; i < 8; i++) if (en[(ptr + i) % 8]) return (ptr + i) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_lane = 0; m_data = 0; m_rr = 0; m_drop = 0;
    endtask

    task automatic drive(bit md, logic [7:0] en, bit v, logic [7:0] d, logic [2:0] s, logic [7:0] ordy);
        bus.mode = md; bus.lane_en = en; bus.in_valid = v;
        bus.in_data = d; bus.in_sel = s; bus.out_ready = ordy;
        #1;
    endtask

    // Compare DUT to model for the current cycle, advance the model, step one clock
    task automatic model_step();
        bit rdy, xfer, acc;
        int tgt;
        rdy  = !(!bus.mode && bus.lane_en == 0) && (!m_hold || bus.out_ready[m_lane]);
        xfer = m_hold && bus.out_ready[m_lane];
        acc  = bus.in_valid && rdy;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("out_valid", 32'(bus.out_valid), m_hold ? (32'd1 << m_lane) : 32'd0);
        if (m_hold) begin
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("cur_lane", 32'(bus.cur_lane), 32'(m_lane));
        end
        check("rr_ptr", 32'(bus.rr_ptr), 32'(m_rr));
        check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        if (acc) begin
            tgt = bus.mode ? int'(bus.in_sel) : rr_scan(m_rr, bus.lane_en);
            if (bus.mode && !bus.lane_en[bus.in_sel]) begin
                if (m_drop < 255) m_drop++;
                m_hold = m_hold && !xfer;
            end else begin
                m_hold = 1; m_lane = tgt; m_data = int'(bus.in_data);
                if (!bus.mode) m_rr = (tgt + 1) % 8;
            end
        end else if (xfer) m_hold = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic plain_reset();
        rst = 1'b1;
        drive(0, 8'hFF, 0, 8'h00, 0, 8'hFF);
        model_reset();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 10; k++)
            tbl[k] = '{0, 8'hFF, 1, 8'(k), 3'd0, 8'hFF, 1,
                       (k == 0) ? 8'h00 : 8'(1 << ((k - 1) % 8)), 8'(k - 1), 3'(k % 8)};
        tbl[10] = '{0, 8'h24, 1, 8'h10, 3'd0, 8'hFF, 1, 8'h02, 8'h09, 3'd2};
        tbl[11] = '{0, 8'h24, 1, 8'h11, 3'd0, 8'hFF, 1, 8'h04, 8'h10, 3'd3};
        tbl[12] = '{0, 8'h24, 1, 8'h12, 3'd0, 8'hFF, 1, 8'h20, 8'h11, 3'd6};
        tbl[13] = '{0, 8'h00, 1, 8'h13, 3'd0, 8'hFF, 0, 8'h04, 8'h12, 3'd3};
        tbl[14] = '{0, 8'h00, 1, 8'h14, 3'd0, 8'hFF, 0, 8'h00, 8'h00, 3'd3};
        tbl[15] = '{1, 8'hFF, 1, 8'h3C, 3'd3, 8'h00, 1, 8'h00, 8'h00, 3'd3};
        for (int k = 16; k < 20; k++)
            tbl[k] = '{1, 8'hFF, 1, 8'h99, 3'd3, 8'hF7, 0, 8'h08, 8'h3C, 3'd3};
        tbl[20] = '{1, 8'hFF, 0, 8'h99, 3'd3, 8'h08, 1, 8'h08, 8'h3C, 3'd3};
        tbl[21] = '{1, 8'hFF, 0, 8'h00, 3'd0, 8'hFF, 1, 8'h00, 8'h00, 3'd3};

        model_reset();
        drive(0, 8'hFF, 0, 8'h00, 0, 8'hFF);
        check("reset_in_ready", 32'(bus.in_ready), 0);
        check("reset_out_valid", 32'(bus.out_valid), 0);
        check("reset_out_data", 32'(bus.out_data), 0);
        check("reset_cur_lane", 32'(bus.cur_lane), 0);
        check("reset_rr_ptr", 32'(bus.rr_ptr), 0);
        check("reset_drop_cnt", 32'(bus.drop_cnt), 0);
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].md, tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].ordy);
            check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            check($sformatf("tbl%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov != 0) check($sformatf("tbl%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
            check($sformatf("tbl%0d_rr_ptr", i), 32'(bus.rr_ptr), 32'(tbl[i].rr));
            model_step();
        end

        // Mode switch: RR -> lane 0, directed -> lane 7, RR -> lane 1
        plain_reset();
        drive(0, 8'hFF, 1, 8'h01, 3'd0, 8'hFF);
        model_step();
        drive(1, 8'hFF, 1, 8'h02, 3'd7, 8'hFF);
        check("msw_lane0", 32'(bus.out_valid), 32'h01);
        model_step();
        drive(0, 8'hFF, 1, 8'h03, 3'd5, 8'hFF);
        check("msw_lane7", 32'(bus.out_valid), 32'h80);
        check("msw_rr_kept", 32'(bus.rr_ptr), 1);
        model_step();
        drive(0, 8'hFF, 0, 8'h00, 3'd0, 8'hFF);
        check("msw_lane1", 32'(bus.out_valid), 32'h02);
        check("msw_rr", 32'(bus.rr_ptr), 2);
        model_step();

        // Directed flood to disabled lane 6: counter saturates, rr_ptr stays at 2
        for (int k = 0; k < 300; k++) begin
            drive(1, 8'hBF, 1, 8'($urandom), 3'd6, 8'hFF);
            model_step();
        end
        drive(1, 8'hBF, 0, 8'h00, 3'd6, 8'hFF);
        check("sat_drop_cnt", 32'(bus.drop_cnt), 255);
        check("sat_rr_ptr", 32'(bus.rr_ptr), 2);
        check("sat_out_valid", 32'(bus.out_valid), 0);

        // Reset asserted while 0xA5 is held and stalled
        drive(1, 8'hFF, 1, 8'hA5, 3'd4, 8'h00);
        model_step();
        drive(1, 8'hFF, 0, 8'h00, 3'd4, 8'h00);
        check("hold_out_valid", 32'(bus.out_valid), 32'h10);
        check("hold_out_data", 32'(bus.out_data), 32'hA5);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_drop_cnt", 32'(bus.drop_cnt), 0);
        check("midrst_rr_ptr", 32'(bus.rr_ptr), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 8'hFF, 0, 8'h00, 3'd4, 8'hFF);
        check("postrst_out_valid", 32'(bus.out_valid), 0);
        model_step();

        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
                  ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
